note_lane_scroller: RTL and testbench

//  Parametrised falling-note lane renderer for the piano game VGA path. Holds LANES x DEPTH note grid,

---
 rtl/note_lane_scroller.sv | 170 +++++++++++++++++
 tb/tb_note_lane_scroller.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_lane_scroller.sv
// note_lane_scroller: falling-note lane grid for the piano game VGA path.
// Scrolls the grid one row per tick toward the hit line, pulls new rows from
// the song player over valid/ready, and renders the pixel colour (1-cycle latency).
// Learn mode holds the scroll until the player presses exactly the bottom-row keys.
// Build macro SCORE_EN: builds the saturating hit/miss counters; otherwise both read 0.
module note_lane_scroller #(
    parameter int unsigned LANES      = 7,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned PERIOD     = 100000,
    parameter int unsigned X0         = 112,
    parameter int unsigned LANE_PITCH = 64,
    parameter int unsigned LANE_W     = 32,
    parameter int unsigned Y_BOTTOM   = 400,
    parameter int unsigned ROW_SHIFT  = 2
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    input  logic             mode,
    input  logic [1:0]       shift,
    input  logic [LANES-1:0] key,
    input  logic             note_valid,
    input  logic [LANES-1:0] note_row,
    output logic             note_ready,
    output logic [LANES-1:0] bottom_row,
    output logic             stalled,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt,
    output logic [23:0]      pos_data
);

    localparam int unsigned CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned ROW_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [23:0] HIT_RGB = 24'hFFF200;
    localparam logic [23:0] NOTE_RGB = 24'h000000;

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [DEPTH-1:0][LANES-1:0] grid_q, grid_d;
    logic                        stalled_q, stalled_d;
    logic [23:0]                 pos_data_q, pos_data_d;

    logic             tick_c;
    logic             advance_c;
    logic [7:0]       bg_t_c;
    logic [23:0]      bg_rgb_c;
    logic [31:0]      row_c;
    logic             row_ok_c;
    logic [ROW_W-1:0] row_idx_c;

    // Scroll-period counter; tick fires on the last count of each period
    always_comb begin
        tick_c = (cnt_q == CNT_W'(PERIOD - 1));
        cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
    end

    // Advance decision: free-run always, learn mode only on empty or exactly-matched bottom row
    always_comb begin
        advance_c = 1'b0;
        if (tick_c) begin
            if (!mode) begin
                advance_c = 1'b1;
            end else if ((grid_q[0] == '0) || (key == grid_q[0])) begin
                advance_c = 1'b1;
            end
        end
    end

    // Grid shift toward the hit line and stall flag update
    always_comb begin
        grid_d    = grid_q;
        stalled_d = stalled_q;
        if (advance_c) begin
            for (int unsigned r = 0; r + 1 < DEPTH; r++) begin
                grid_d[r] = grid_q[r + 1];
            end
            grid_d[DEPTH-1] = note_valid ? note_row : '0;
        end
        if (tick_c) begin
            stalled_d = !advance_c;
        end
    end

    // Background gradient for the selected pitch band
    always_comb begin
        bg_t_c = 8'(((32'(pos_y) * 32'd2) / 32'd3) - 32'd1);
        case (shift)
            2'b10:   bg_rgb_c = {bg_t_c, bg_t_c, 8'hFF};
            2'b01:   bg_rgb_c = {8'hFF, bg_t_c, bg_t_c};
            default: bg_rgb_c = 24'hFFFFFF;
        endcase
    end

    // Pixel colour: lit grid cells over background, hit colour on pressed bottom-row notes
    always_comb begin
        row_c      = '0;
        row_ok_c   = 1'b0;
        pos_data_d = bg_rgb_c;
        if (32'(pos_y) < Y_BOTTOM) begin
            row_c    = (Y_BOTTOM - 32'd1 - 32'(pos_y)) >> ROW_SHIFT;
            row_ok_c = (row_c < DEPTH);
        end
        row_idx_c = ROW_W'(row_c);
        for (int unsigned l = 0; l < LANES; l++) begin
            if (row_ok_c
                && (32'(pos_x) >= X0 + l * LANE_PITCH)
                && (32'(pos_x) <  X0 + l * LANE_PITCH + LANE_W)
                && grid_q[row_idx_c][l]) begin
                pos_data_d = ((row_idx_c == '0) && key[l]) ? HIT_RGB : NOTE_RGB;
            end
        end
    end

    // State registers
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            grid_q     <= '0;
            stalled_q  <= 1'b0;
            pos_data_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            grid_q     <= grid_d;
            stalled_q  <= stalled_d;
            pos_data_q <= pos_data_d;
        end
    end

`ifdef SCORE_EN
    logic [15:0] hit_q, hit_d;
    logic [15:0] miss_q, miss_d;
    logic [16:0] hit_sum_c;
    logic [16:0] miss_sum_c;

    // Saturating score update from the row leaving the grid
    always_comb begin
        hit_sum_c  = 17'(hit_q)  + 17'($countones(grid_q[0] & key));
        miss_sum_c = 17'(miss_q) + 17'($countones(grid_q[0] & ~key));
        hit_d      = hit_q;
        miss_d     = miss_q;
        if (advance_c) begin
            hit_d  = hit_sum_c[16]  ? 16'hFFFF : hit_sum_c[15:0];
            miss_d = miss_sum_c[16] ? 16'hFFFF : miss_sum_c[15:0];
        end
    end

    // Score registers
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = 16'h0;
    assign miss_cnt = 16'h0;
`endif

    assign note_ready = advance_c;
    assign bottom_row = grid_q[0];
    assign stalled    = stalled_q;
    assign pos_data   = pos_data_q;

endmodule

// File: tb/tb_note_lane_scroller.sv
// Scoreboard bench for note_lane_scroller: stimulus queues expected values tagged
// with the cycle they must appear on; a negedge monitor compares them.
// A second instance with a one-cycle period drives the score counter into saturation.
module tb_note_lane_scroller;

    localparam int unsigned LANES = 3;

`ifdef SCORE_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst2_n;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       mode;
    logic [1:0] shift;
    logic [2:0] key;
    logic       note_valid;
    logic [2:0] note_row;

    logic        note_ready;
    logic [2:0]  bottom_row;
    logic        stalled;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    logic [23:0] pos_data;

    logic        note_ready2;
    logic [2:0]  bottom_row2;
    logic        stalled2;
    logic [15:0] hit_cnt2;
    logic [15:0] miss_cnt2;
    logic [23:0] pos_data2;

    note_lane_scroller #(
        .LANES(3), .DEPTH(4), .PERIOD(4), .X0(112), .LANE_PITCH(64),
        .LANE_W(32), .Y_BOTTOM(400), .ROW_SHIFT(2)
    ) dut (
        .vga_clk(clk), .rst_n(rst_n), .pos_x(pos_x), .pos_y(pos_y),
        .mode(mode), .shift(shift), .key(key), .note_valid(note_valid),
        .note_row(note_row), .note_ready(note_ready), .bottom_row(bottom_row),
        .stalled(stalled), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .pos_data(pos_data)
    );

    note_lane_scroller #(
        .LANES(3), .DEPTH(4), .PERIOD(1), .X0(112), .LANE_PITCH(64),
        .LANE_W(32), .Y_BOTTOM(400), .ROW_SHIFT(2)
    ) dut_sat (
        .vga_clk(clk), .rst_n(rst2_n), .pos_x(10'd0), .pos_y(10'd0),
        .mode(1'b0), .shift(2'b00), .key(3'b011), .note_valid(1'b1),
        .note_row(3'b111), .note_ready(note_ready2), .bottom_row(bottom_row2),
        .stalled(stalled2), .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2), .pos_data(pos_data2)
    );

    typedef struct {
        int          at;
        int          sel;
        logic [31:0] val;
        string       name;
    } chk_t;

    chk_t sb[$];
    chk_t keep[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            0:       return 32'(note_ready);
            1:       return 32'(bottom_row);
            2:       return 32'(stalled);
            3:       return 32'(hit_cnt);
            4:       return 32'(miss_cnt);
            5:       return 32'(pos_data);
            6:       return 32'(hit_cnt2);
            7:       return 32'(miss_cnt2);
            8:       return 32'(stalled2);
            9:       return 32'(pos_data2);
            10:      return 32'(bottom_row2);
            11:      return 32'(note_ready2);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [31:0] sc(input logic [31:0] v);
        return SC ? v : 32'd0;
    endfunction

    task automatic expect_at(input int at, input int sel, input logic [31:0] v, input string nm);
        chk_t c;
        c.at   = at;
        c.sel  = sel;
        c.val  = v;
        c.name = nm;
        sb.push_back(c);
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every queued expectation due on this cycle
    always @(negedge clk) begin
        logic [31:0] got;
        keep.delete();
        foreach (sb[i]) begin
            if (sb[i].at == cyc) begin
                n_tests++;
                got = probe(sb[i].sel);
                if (got !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %h, expected %h", sb[i].name, cyc, got, sb[i].val);
                end
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    initial begin
        int r;
        int p;
        int q;
        int s;

        rst_n = 1'b0; rst2_n = 1'b0;
        pos_x = '0; pos_y = '0; mode = 1'b0; shift = 2'b00;
        key = '0; note_valid = 1'b0; note_row = '0;

        step_to(2);
        r = cyc;
        expect_at(r, 0, 32'd0, "rst_note_ready");
        expect_at(r, 1, 32'd0, "rst_bottom_row");
        expect_at(r, 2, 32'd0, "rst_stalled");
        expect_at(r, 3, 32'd0, "rst_hit_cnt");
        expect_at(r, 4, 32'd0, "rst_miss_cnt");
        expect_at(r, 5, 32'd0, "rst_pos_data");
        expect_at(r, 6, 32'd0, "rst_sat_hit_cnt");
        rst_n = 1'b1; rst2_n = 1'b1;
        note_valid = 1'b1; note_row = 3'b101;

        // Free-run: note_ready every PERIOD cycles, row reaches bottom on 4th tick
        expect_at(r + 3,  0, 32'd1, "t1_ready_tick1");
        expect_at(r + 4,  0, 32'd0, "t1_ready_low");
        expect_at(r + 6,  0, 32'd0, "t1_ready_low2");
        expect_at(r + 7,  0, 32'd1, "t1_ready_tick2");
        expect_at(r + 11, 0, 32'd1, "t1_ready_tick3");
        expect_at(r + 15, 0, 32'd1, "t1_ready_tick4");
        expect_at(r + 15, 1, 32'd0, "t1_bottom_before");
        expect_at(r + 16, 1, 32'b101, "t1_bottom_after");
        expect_at(r + 16, 2, 32'd0, "t1_stalled");

        // Scoring one hit and one miss
        step_to(r + 16);
        n_tests++;
        if (bottom_row !== 3'b101) begin
            n_fail++;
            $display("FAIL d1_bottom: got %b, expected 101", bottom_row);
        end
        n_tests++;
        if (stalled !== 1'b0) begin
            n_fail++;
            $display("FAIL d1_stalled: got %b, expected 0", stalled);
        end
        key = 3'b001;
        expect_at(r + 19, 3, sc(32'd0), "t2_hit_before");
        expect_at(r + 20, 3, sc(32'd1), "t2_hit");
        expect_at(r + 20, 4, sc(32'd1), "t2_miss");

        step_to(r + 20);
        n_tests++;
        if (32'(hit_cnt) !== sc(32'd1)) begin
            n_fail++;
            $display("FAIL d2_hit: got %h", hit_cnt);
        end
        n_tests++;
        if (32'(miss_cnt) !== sc(32'd1)) begin
            n_fail++;
            $display("FAIL d2_miss: got %h", miss_cnt);
        end
        note_row = 3'b011; key = 3'b101;
        expect_at(r + 36, 3, sc(32'd9), "t3_hit_pre");
        expect_at(r + 36, 4, sc(32'd1), "t3_miss_pre");
        expect_at(r + 36, 1, 32'b011, "t3_bottom_pre");
        expect_at(r + 36, 2, 32'd0, "t3_stalled_pre");

        // Learn mode with partial keys stalls and freezes the grid
        step_to(r + 37);
        mode = 1'b1; key = 3'b001;
        expect_at(r + 39, 0, 32'd0, "t3_ready_blocked");
        expect_at(r + 40, 2, 32'd1, "t3_stalled");
        expect_at(r + 40, 1, 32'b011, "t3_frozen");
        expect_at(r + 40, 3, sc(32'd9), "t3_hit_frozen");
        expect_at(r + 43, 0, 32'd0, "t3_ready_blocked2");
        expect_at(r + 44, 2, 32'd1, "t3_stalled2");
        expect_at(r + 44, 1, 32'b011, "t3_frozen2");

        step_to(r + 44);
        n_tests++;
        if (stalled !== 1'b1) begin
            n_fail++;
            $display("FAIL d3_stalled: got %b, expected 1", stalled);
        end
        n_tests++;
        if (bottom_row !== 3'b011) begin
            n_fail++;
            $display("FAIL d3_frozen: got %b, expected 011", bottom_row);
        end
        key = 3'b011;
        expect_at(r + 47, 0, 32'd1, "t3_ready_release");
        expect_at(r + 48, 3, sc(32'd11), "t3_hit_release");
        expect_at(r + 48, 4, sc(32'd1), "t3_miss_release");
        expect_at(r + 48, 2, 32'd0, "t3_unstalled");
        expect_at(r + 48, 1, 32'b011, "t3_bottom_release");

        // Extra held key blocks advance
        step_to(r + 48);
        n_tests++;
        if (stalled !== 1'b0) begin
            n_fail++;
            $display("FAIL d4_unstalled: got %b, expected 0", stalled);
        end
        n_tests++;
        if (32'(hit_cnt) !== sc(32'd11)) begin
            n_fail++;
            $display("FAIL d4_hit: got %h", hit_cnt);
        end
        n_tests++;
        if (bottom_row !== 3'b011) begin
            n_fail++;
            $display("FAIL d4_bottom: got %b, expected 011", bottom_row);
        end
        note_row = 3'b001;
        expect_at(r + 64, 3, sc(32'd19), "t4_hit_pre");
        expect_at(r + 64, 1, 32'b001, "t4_bottom_pre");
        expect_at(r + 64, 2, 32'd0, "t4_stalled_pre");
        expect_at(r + 67, 0, 32'd0, "t4_ready_blocked");
        expect_at(r + 68, 2, 32'd1, "t4_stalled");
        expect_at(r + 68, 1, 32'b001, "t4_frozen");

        // Back to free-run with no keys: misses counted, lane 1 fills the grid
        step_to(r + 68);
        n_tests++;
        if (stalled !== 1'b1) begin
            n_fail++;
            $display("FAIL d5_stalled: got %b, expected 1", stalled);
        end
        n_tests++;
        if (bottom_row !== 3'b001) begin
            n_fail++;
            $display("FAIL d5_frozen: got %b, expected 001", bottom_row);
        end
        mode = 1'b0; key = 3'b000; note_row = 3'b010;
        expect_at(r + 72, 2, 32'd0, "t5_unstalled");
        expect_at(r + 84, 4, sc(32'd5), "t5_miss");
        expect_at(r + 84, 3, sc(32'd19), "t5_hit");
        expect_at(r + 84, 1, 32'b010, "t5_bottom");

        // Pixel rendering
        p = r + 85;
        step_to(p);
        key = 3'b010; pos_x = 10'd176; pos_y = 10'd399; shift = 2'b00;
        expect_at(p + 1, 5, 32'hFFF200, "px_hit_color");
        step_to(p + 1);
        key = 3'b000;
        expect_at(p + 2, 5, 32'h000000, "px_note_black");
        step_to(p + 2);
        pos_x = 10'd144; shift = 2'b10;
        expect_at(p + 3, 5, 32'h0909FF, "px_gap_high");
        step_to(p + 3);
        shift = 2'b01;
        expect_at(p + 4, 5, 32'hFF0909, "px_gap_low");
        step_to(p + 4);
        shift = 2'b00; pos_x = 10'd300;
        expect_at(p + 5, 5, 32'hFFFFFF, "px_past_lanes");
        step_to(p + 5);
        pos_x = 10'd207; key = 3'b010;
        expect_at(p + 6, 5, 32'hFFF200, "px_lane_last_col");
        step_to(p + 6);
        pos_x = 10'd208; shift = 2'b10;
        expect_at(p + 7, 5, 32'h0909FF, "px_lane_end");
        step_to(p + 7);
        pos_x = 10'd176; pos_y = 10'd395;
        expect_at(p + 8, 5, 32'h000000, "px_row1_black");
        step_to(p + 8);
        pos_y = 10'd383;
        expect_at(p + 9, 5, 32'hFEFEFF, "px_above_grid");
        step_to(p + 9);
        pos_y = 10'd400; shift = 2'b01;
        expect_at(p + 10, 5, 32'hFF0909, "px_below_grid");
        step_to(p + 10);
        pos_x = 10'd112; pos_y = 10'd399; shift = 2'b00; key = 3'b001;
        expect_at(p + 11, 5, 32'hFFFFFF, "px_empty_cell");

        // Async reset mid-period
        q = p + 12;
        step_to(q);
        rst_n = 1'b0;
        expect_at(q, 0, 32'd0, "t6_rst_ready");
        expect_at(q, 1, 32'd0, "t6_rst_bottom");
        expect_at(q, 2, 32'd0, "t6_rst_stalled");
        expect_at(q, 3, 32'd0, "t6_rst_hit");
        expect_at(q, 4, 32'd0, "t6_rst_miss");
        expect_at(q, 5, 32'd0, "t6_rst_pos_data");
        step_to(q + 2);
        rst_n = 1'b1;
        expect_at(q + 4, 0, 32'd0, "t6_no_early_tick");
        expect_at(q + 5, 0, 32'd1, "t6_first_tick");
        expect_at(q + 6, 1, 32'd0, "t6_bottom_empty");

        // Saturation on the fast instance: 2 hits and 1 miss per cycle from cycle r+5
        s = r + 4 + 32767;
        expect_at(s,     6, sc(32'hFFFE), "t6_sat_fffe");
        expect_at(s,     10, 32'b111, "t6_sat_bottom");
        expect_at(s,     11, 32'd1, "t6_sat_ready");
        expect_at(s,     8, 32'd0, "t6_sat_stalled");
        expect_at(s,     9, 32'hFFFFFF, "t6_sat_pos_data");
        expect_at(s + 1, 6, sc(32'hFFFF), "t6_sat_ffff");
        expect_at(s + 1, 7, sc(32'h8000), "t6_sat_miss");
        expect_at(s + 3, 6, sc(32'hFFFF), "t6_sat_hold");
        step_to(s + 6);

        foreach (sb[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never compared, expected %h at cyc %0d", sb[i].name, sb[i].val, sb[i].at);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
